// File: rtl/load_store_unit_pkg.sv
// Shared constants, state encoding and access-legality decode for the load/store unit.
package load_store_unit_pkg;

  localparam int LSU_ADDR_WIDTH     = 32;
  localparam int LSU_MEM_ADDR_WIDTH = 10;
  localparam int LSU_WORD_WIDTH     = 32;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic {
    LSU_STATE_IDLE  = 1'b0,
    LSU_STATE_MERGE = 1'b1
  } lsu_state_e;

  // funct3[1:0] encodes the access size for every legal load and store.
  function automatic logic lsu_access_err(input logic we, input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (we)
      illegal = !(funct3 == FUNCT3_SB || funct3 == FUNCT3_SH || funct3 == FUNCT3_SW);
    else
      illegal = !(funct3 == FUNCT3_LB || funct3 == FUNCT3_LH || funct3 == FUNCT3_LW ||
                  funct3 == FUNCT3_LBU || funct3 == FUNCT3_LHU);
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
    return illegal | misaligned;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = LSU_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH = LSU_MEM_ADDR_WIDTH,
  parameter int WORD_WIDTH     = LSU_WORD_WIDTH
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [2:0]                req_funct3;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [WORD_WIDTH-1:0]     req_wdata;
  logic                      resp_valid;
  logic [WORD_WIDTH-1:0]     resp_rdata;
  logic                      resp_err;
  logic                      mem_wen;
  logic [2:0]                mem_type;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0]     mem_wd;
  logic [WORD_WIDTH-1:0]     mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_wen, mem_type, mem_addr, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_wen, mem_type, mem_addr, mem_wd
  );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: load byte/half extract with extension, and store byte/half merge.
module load_store_unit_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [LSU_WORD_WIDTH-1:0] ld_word,
  input  logic [1:0]                ld_offset,
  input  logic [2:0]                ld_funct3,
  output logic [LSU_WORD_WIDTH-1:0] ld_data,
  input  logic [LSU_WORD_WIDTH-1:0] st_word,
  input  logic [1:0]                st_offset,
  input  logic                      st_half,
  input  logic [15:0]               st_wdata,
  output logic [LSU_WORD_WIDTH-1:0] st_merged
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_hw;

  always_comb begin
    ld_byte = ld_word[8*ld_offset +: 8];
    ld_hw   = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_funct3)
      FUNCT3_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      FUNCT3_LBU: ld_data = {24'd0, ld_byte};
      FUNCT3_LH:  ld_data = {{16{ld_hw[15]}}, ld_hw};
      FUNCT3_LHU: ld_data = {16'd0, ld_hw};
      default:    ld_data = ld_word;
    endcase
  end

  always_comb begin
    st_merged = st_word;
    if (st_half) begin
      if (st_offset[1]) st_merged[31:16] = st_wdata;
      else              st_merged[15:0]  = st_wdata;
    end else begin
      st_merged[8*st_offset +: 8] = st_wdata[7:0];
    end
  end
endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed memory; SB/SH use read-modify-write.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_WIDTH     = LSU_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH = LSU_MEM_ADDR_WIDTH,
  parameter int WORD_WIDTH     = LSU_WORD_WIDTH
)(
  input  logic            clk,
  input  logic            rst_n,
  load_store_unit_if.slave bus
);
  lsu_state_e                state;
  logic                      accept;
  logic                      req_err;
  logic                      sw_go;
  logic                      wen;
  logic [WORD_WIDTH-1:0]     ld_data;
  logic [WORD_WIDTH-1:0]     merged;
  logic                      vld_p1;
  logic                      resp_err_p1;
  logic [WORD_WIDTH-1:0]     resp_rdata_p1;
  logic [WORD_WIDTH-1:0]     word_p1;
  logic [MEM_ADDR_WIDTH-1:0] addr_p1;
  logic [1:0]                off_p1;
  logic                      half_p1;
  logic [15:0]               wdata_p1;
  logic                      unused_addr_hi;

  assign unused_addr_hi = ^bus.req_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2];

  assign bus.req_ready = (state == LSU_STATE_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;
  assign req_err       = lsu_access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);
  assign sw_go         = accept && bus.req_we && !req_err && (bus.req_funct3 == FUNCT3_SW);

  load_store_unit_lane_align u_align (
    .ld_word   (bus.mem_rd),
    .ld_offset (bus.req_addr[1:0]),
    .ld_funct3 (bus.req_funct3),
    .ld_data   (ld_data),
    .st_word   (word_p1),
    .st_offset (off_p1),
    .st_half   (half_p1),
    .st_wdata  (wdata_p1),
    .st_merged (merged)
  );

  // Memory port: held RMW write in MERGE, otherwise follows the live request.
  always_comb begin
    wen          = 1'b0;
    bus.mem_addr = bus.req_addr[MEM_ADDR_WIDTH+1:2];
    bus.mem_wd   = '0;
    if (state == LSU_STATE_MERGE) begin
      wen          = 1'b1;
      bus.mem_addr = addr_p1;
      bus.mem_wd   = merged;
    end else if (sw_go) begin
      wen        = 1'b1;
      bus.mem_wd = bus.req_wdata;
    end
    bus.mem_wen  = wen;
    bus.mem_type = wen ? FUNCT3_SW : FUNCT3_LW;
  end

  // Stage p1: FSM and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LSU_STATE_IDLE;
      vld_p1        <= 1'b0;
      resp_err_p1   <= 1'b0;
      resp_rdata_p1 <= '0;
    end else begin
      vld_p1        <= 1'b0;
      resp_err_p1   <= 1'b0;
      resp_rdata_p1 <= '0;
      case (state)
        LSU_STATE_IDLE: begin
          if (accept) begin
            if (req_err) begin
              vld_p1      <= 1'b1;
              resp_err_p1 <= 1'b1;
            end else if (!bus.req_we) begin
              vld_p1        <= 1'b1;
              resp_rdata_p1 <= ld_data;
            end else if (bus.req_funct3 == FUNCT3_SW) begin
              vld_p1 <= 1'b1;
            end else begin
              state <= LSU_STATE_MERGE;
            end
          end
        end
        LSU_STATE_MERGE: begin
          state  <= LSU_STATE_IDLE;
          vld_p1 <= 1'b1;
        end
        default: state <= LSU_STATE_IDLE;
      endcase
    end
  end

  // RMW operand latches; only meaningful while MERGE is entered.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !req_err && (bus.req_funct3 != FUNCT3_SW)) begin
      word_p1  <= bus.mem_rd;
      addr_p1  <= bus.req_addr[MEM_ADDR_WIDTH+1:2];
      off_p1   <= bus.req_addr[1:0];
      half_p1  <= bus.req_funct3[0];
      wdata_p1 <= bus.req_wdata[15:0];
    end
  end

  assign bus.resp_valid = vld_p1;
  assign bus.resp_err   = resp_err_p1;
  assign bus.resp_rdata = resp_rdata_p1;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-indexed memory model behind the unit.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [0:1023];
  logic        pk_en;
  logic [9:0]  pk_addr;
  logic [31:0] pk_data;

  assign bus.mem_rd = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (pk_en)            mem[pk_addr]      <= pk_data;
    else if (bus.mem_wen) mem[bus.mem_addr] <= bus.mem_wd;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    #1;
  endtask

  task automatic idle();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    #1;
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    pk_en   = 1'b1;
    pk_addr = a;
    pk_data = d;
    tick();
    pk_en   = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
    req(1'b0, f3, addr, 32'h0);
    tick();
    idle();
    chk({tag, "_vld"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_err"}, {31'd0, bus.resp_err}, 32'd0);
    chk({tag, "_rdata"}, bus.resp_rdata, exp);
  endtask

  task automatic sw_do(input logic [31:0] addr, input logic [31:0] d);
    req(1'b1, FUNCT3_SW, addr, d);
    tick();
    idle();
  endtask

  initial begin
    pk_en = 1'b0;
    pk_addr = '0;
    pk_data = '0;
    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_vld", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    chk("rst_err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst_wen", {31'd0, bus.mem_wen}, 32'd0);
    chk("rst_maddr", {22'd0, bus.mem_addr}, 32'h0);
    poke(10'd4, 32'h1122_3344);
    poke(10'd8, 32'hCAFE_F00D);
    poke(10'd12, 32'h5566_7788);
    rst_n = 1'b1;
    tick();

    // Sub-word loads from 0x11223344
    load_chk("lb13", FUNCT3_LB, 32'h13, 32'h0000_0011);
    load_chk("lb10", FUNCT3_LB, 32'h10, 32'h0000_0044);
    load_chk("lh12", FUNCT3_LH, 32'h12, 32'h0000_1122);

    // SW then extension checks on 0x80FF0000
    req(1'b1, FUNCT3_SW, 32'h10, 32'h80FF_0000);
    chk("sw_wen", {31'd0, bus.mem_wen}, 32'd1);
    chk("sw_maddr", {22'd0, bus.mem_addr}, 32'd4);
    chk("sw_wd", bus.mem_wd, 32'h80FF_0000);
    tick();
    idle();
    chk("sw_vld", {31'd0, bus.resp_valid}, 32'd1);
    chk("sw_rdata", bus.resp_rdata, 32'h0);
    load_chk("lhu12", FUNCT3_LHU, 32'h12, 32'h0000_80FF);
    load_chk("lh12n", FUNCT3_LH, 32'h12, 32'hFFFF_80FF);
    load_chk("lb13n", FUNCT3_LB, 32'h13, 32'hFFFF_FF80);
    load_chk("lbu13", FUNCT3_LBU, 32'h13, 32'h0000_0080);

    // SB read-modify-write
    sw_do(32'h10, 32'h1122_3344);
    req(1'b1, FUNCT3_SB, 32'h11, 32'h1234_56AB);
    chk("sb_t_wen", {31'd0, bus.mem_wen}, 32'd0);
    tick();
    idle();
    chk("sb_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("sb_wen", {31'd0, bus.mem_wen}, 32'd1);
    chk("sb_maddr", {22'd0, bus.mem_addr}, 32'd4);
    chk("sb_wd", bus.mem_wd, 32'h1122_AB44);
    chk("sb_vld1", {31'd0, bus.resp_valid}, 32'd0);
    tick();
    chk("sb_vld2", {31'd0, bus.resp_valid}, 32'd1);
    chk("sb_ready2", {31'd0, bus.req_ready}, 32'd1);
    load_chk("sb_rb", FUNCT3_LW, 32'h10, 32'h1122_AB44);

    // SH with a LW held off during MERGE
    req(1'b1, FUNCT3_SH, 32'h22, 32'h0000_BEEF);
    tick();
    req(1'b0, FUNCT3_LW, 32'h20, 32'h0);
    chk("sh_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("sh_wd", bus.mem_wd, 32'hBEEF_F00D);
    tick();
    chk("sh_vld", {31'd0, bus.resp_valid}, 32'd1);
    chk("sh_err", {31'd0, bus.resp_err}, 32'd0);
    tick();
    idle();
    chk("lw20_vld", {31'd0, bus.resp_valid}, 32'd1);
    chk("lw20_rdata", bus.resp_rdata, 32'hBEEF_F00D);

    // Misalignment
    req(1'b0, FUNCT3_LW, 32'h21, 32'h0);
    chk("lw21_wen", {31'd0, bus.mem_wen}, 32'd0);
    tick();
    idle();
    chk("lw21_vld", {31'd0, bus.resp_valid}, 32'd1);
    chk("lw21_err", {31'd0, bus.resp_err}, 32'd1);
    chk("lw21_rdata", bus.resp_rdata, 32'h0);
    req(1'b1, FUNCT3_SH, 32'h23, 32'h0000_1234);
    chk("sh23_wen", {31'd0, bus.mem_wen}, 32'd0);
    tick();
    idle();
    chk("sh23_err", {31'd0, bus.resp_err}, 32'd1);
    chk("sh23_ready", {31'd0, bus.req_ready}, 32'd1);
    load_chk("lb23", FUNCT3_LB, 32'h23, 32'hFFFF_FFBE);

    // Back-to-back SW/SW/LW/LW
    req(1'b1, FUNCT3_SW, 32'h0, 32'hA5A5_0001);
    chk("b2b_rdy0", {31'd0, bus.req_ready}, 32'd1);
    tick();
    req(1'b1, FUNCT3_SW, 32'h4, 32'h0000_7E02);
    chk("b2b_rdy1", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_vld0", {31'd0, bus.resp_valid}, 32'd1);
    tick();
    req(1'b0, FUNCT3_LW, 32'h0, 32'h0);
    chk("b2b_rdy2", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_vld1", {31'd0, bus.resp_valid}, 32'd1);
    tick();
    req(1'b0, FUNCT3_LW, 32'h4, 32'h0);
    chk("b2b_rdy3", {31'd0, bus.req_ready}, 32'd1);
    chk("b2b_vld2", {31'd0, bus.resp_valid}, 32'd1);
    chk("b2b_rd2", bus.resp_rdata, 32'hA5A5_0001);
    tick();
    idle();
    chk("b2b_vld3", {31'd0, bus.resp_valid}, 32'd1);
    chk("b2b_rd3", bus.resp_rdata, 32'h0000_7E02);
    tick();
    chk("b2b_end", {31'd0, bus.resp_valid}, 32'd0);

    // Illegal funct3
    load_chk("ld011_pre", FUNCT3_LW, 32'h4, 32'h0000_7E02);
    req(1'b0, 3'b011, 32'h0, 32'h0);
    tick();
    idle();
    chk("ill_vld", {31'd0, bus.resp_valid}, 32'd1);
    chk("ill_err", {31'd0, bus.resp_err}, 32'd1);
    req(1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF);
    chk("ill_st_wen", {31'd0, bus.mem_wen}, 32'd0);
    tick();
    idle();
    chk("ill_st_err", {31'd0, bus.resp_err}, 32'd1);

    // Reset during MERGE abandons the write
    req(1'b1, FUNCT3_SB, 32'h30, 32'h0000_00EE);
    tick();
    idle();
    chk("rm_wen", {31'd0, bus.mem_wen}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rm_wen_drop", {31'd0, bus.mem_wen}, 32'd0);
    chk("rm_ready", {31'd0, bus.req_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    chk("rm_vld0", {31'd0, bus.resp_valid}, 32'd0);
    tick();
    chk("rm_vld1", {31'd0, bus.resp_valid}, 32'd0);
    chk("rm_ready2", {31'd0, bus.req_ready}, 32'd1);
    load_chk("rm_word", FUNCT3_LW, 32'h30, 32'h5566_7788);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
